// File: rtl/chan_fifo_mem.sv
// rtl/chan_fifo_mem.sv - storage array behind the chan_fifo output register
// Simple dual-port array: synchronous write with enable, combinational read, no reset.
module chan_fifo_mem #(
   parameter int WIDTH   = 8,
   parameter int ENTRIES = 3,
   parameter int PW      = 2
) (
   input  logic             clock,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [ENTRIES];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/chan_fifo.sv
// rtl/chan_fifo.sv - valid/ready channel FIFO with registered handshake outputs
// Output register backed by a DEPTH-1 entry circular array; the output register loads from the array first, else bypasses idata.
module chan_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [WIDTH-1:0]           idata,
   input  logic                       ivalid,
   output logic                       iready,
   output logic [WIDTH-1:0]           odata,
   output logic                       ovalid,
   input  logic                       oready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int SDEPTH = DEPTH - 1;
   localparam int PW     = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
   localparam int CW     = $clog2(DEPTH + 1);

   logic [PW-1:0]    rptr, wptr, rptr_nxt, wptr_nxt;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] odata_nxt;
   logic [WIDTH-1:0] arr_head;
   logic             push, pop, out_free, arr_nonempty;
   logic             load_arr, bypass, arr_we;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(SDEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   assign push         = ivalid & iready;
   assign pop          = ovalid & oready;
   assign out_free     = ~ovalid | oready;
   // ovalid is set whenever count>0, so the array holds count-1 words when non-empty
   assign arr_nonempty = (count > CW'(1));
   assign load_arr     = out_free & arr_nonempty;
   assign bypass       = out_free & ~arr_nonempty & push;
   assign arr_we       = push & ~bypass;

   chan_fifo_mem #(
      .WIDTH   (WIDTH),
      .ENTRIES (SDEPTH),
      .PW      (PW)
   ) u_mem (
      .clock (clock),
      .we    (arr_we),
      .waddr (wptr),
      .wdata (idata),
      .raddr (rptr),
      .rdata (arr_head)
   );

   always_comb begin
      count_nxt = count;
      rptr_nxt  = rptr;
      wptr_nxt  = wptr;
      odata_nxt = odata;
      if (push && !pop) begin
         count_nxt = count + CW'(1);
      end else if (pop && !push) begin
         count_nxt = count - CW'(1);
      end
      if (load_arr) begin
         odata_nxt = arr_head;
         rptr_nxt  = ptr_inc(rptr);
      end else if (bypass) begin
         odata_nxt = idata;
      end
      if (arr_we) begin
         wptr_nxt = ptr_inc(wptr);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count  <= '0;
         rptr   <= '0;
         wptr   <= '0;
         odata  <= '0;
         ovalid <= 1'b0;
         iready <= 1'b1;
      end else begin
         count  <= count_nxt;
         rptr   <= rptr_nxt;
         wptr   <= wptr_nxt;
         odata  <= odata_nxt;
         ovalid <= (count_nxt != '0);
         iready <= (count_nxt < CW'(DEPTH));
      end
   end

endmodule

// File: tb/tb_chan_fifo.sv
// tb/tb_chan_fifo.sv - scoreboard bench for chan_fifo (WIDTH=8, DEPTH=4)
module tb_chan_fifo;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] idata = 8'h00;
   logic       ivalid = 1'b0;
   logic       iready;
   logic [7:0] odata;
   logic       ovalid;
   logic       oready = 1'b0;
   logic [2:0] count;

   int tests = 0;
   int fails = 0;

   logic [7:0] mq[$];
   logic [7:0] mlast = 8'h00;

   always #5 clock = ~clock;

   chan_fifo #(.WIDTH(8), .DEPTH(4)) dut (
      .clock  (clock),
      .resetn (resetn),
      .idata  (idata),
      .ivalid (ivalid),
      .iready (iready),
      .odata  (odata),
      .ovalid (ovalid),
      .oready (oready),
      .count  (count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // reference model: pushes record expected words, pops retire them
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mq.delete();
         mlast = 8'h00;
      end else begin
         logic mpush, mpop;
         mpop  = oready && (mq.size() > 0);
         mpush = ivalid && (mq.size() < 4);
         if (mpop) begin
            mlast = mq.pop_front();
         end
         if (mpush) begin
            mq.push_back(idata);
         end
      end
   end

   always @(negedge clock) begin
      int n;
      n = mq.size();
      check("mon_count",  {29'd0, count}, n);
      check("mon_iready", {31'd0, iready}, {31'd0, (n < 4)});
      check("mon_ovalid", {31'd0, ovalid}, {31'd0, (n > 0)});
      check("mon_odata",  {24'd0, odata}, {24'd0, (n > 0) ? mq[0] : mlast});
   end

   initial begin
      logic [7:0] fillv [4];
      fillv[0] = 8'h11; fillv[1] = 8'h22; fillv[2] = 8'h33; fillv[3] = 8'h44;

      repeat (2) cyc();
      resetn = 1'b1;
      cyc();
      check("idle_iready", {31'd0, iready}, 32'd1);
      check("idle_ovalid", {31'd0, ovalid}, 32'd0);
      check("idle_count",  {29'd0, count}, 32'd0);
      check("idle_odata",  {24'd0, odata}, 32'd0);

      // fill with the consumer stalled
      for (int i = 0; i < 4; i++) begin
         ivalid = 1'b1; idata = fillv[i]; oready = 1'b0;
         cyc();
         check("fill_count", {29'd0, count}, i + 1);
         check("fill_odata", {24'd0, odata}, 32'h11);
      end
      check("full_iready", {31'd0, iready}, 32'd0);
      idata = 8'h55;
      cyc();
      check("full_reject_count", {29'd0, count}, 32'd4);
      check("full_reject_odata", {24'd0, odata}, 32'h11);
      ivalid = 1'b0;

      // drain
      for (int i = 0; i < 4; i++) begin
         check("drain_odata", {24'd0, odata}, {24'd0, fillv[i]});
         oready = 1'b1;
         cyc();
         if (i == 0) check("drain_iready_after_pop", {31'd0, iready}, 32'd1);
      end
      check("drain_ovalid", {31'd0, ovalid}, 32'd0);
      check("drain_count",  {29'd0, count}, 32'd0);
      check("drain_odata_hold", {24'd0, odata}, 32'h44);

      // streaming
      for (int i = 0; i < 64; i++) begin
         ivalid = 1'b1; oready = 1'b1; idata = 8'(i);
         cyc();
         check("stream_count", {29'd0, count}, 32'd1);
         check("stream_odata", {24'd0, odata}, i);
      end
      ivalid = 1'b0;
      cyc();
      check("stream_end_count", {29'd0, count}, 32'd0);

      // simultaneous push/pop at count=2
      oready = 1'b0; ivalid = 1'b1;
      idata = 8'hA1; cyc();
      idata = 8'hA2; cyc();
      check("sim_pre_count", {29'd0, count}, 32'd2);
      oready = 1'b1; idata = 8'hA3; cyc();
      check("sim_count", {29'd0, count}, 32'd2);
      check("sim_odata", {24'd0, odata}, 32'hA2);
      ivalid = 1'b0;
      cyc();
      check("sim_next_odata", {24'd0, odata}, 32'hA3);
      cyc();
      check("sim_drain_count", {29'd0, count}, 32'd0);

      // asynchronous reset with three words held
      oready = 1'b0; ivalid = 1'b1;
      idata = 8'hB1; cyc();
      idata = 8'hB2; cyc();
      idata = 8'hB3; cyc();
      ivalid = 1'b0;
      check("prereset_count", {29'd0, count}, 32'd3);
      #2 resetn = 1'b0;
      #1;
      check("areset_iready", {31'd0, iready}, 32'd1);
      check("areset_ovalid", {31'd0, ovalid}, 32'd0);
      check("areset_count",  {29'd0, count}, 32'd0);
      check("areset_odata",  {24'd0, odata}, 32'd0);
      cyc();
      resetn = 1'b1;
      cyc();

      // random traffic
      for (int i = 0; i < 10000; i++) begin
         ivalid = 1'($urandom_range(0, 1));
         oready = 1'($urandom_range(0, 1));
         idata  = 8'($urandom);
         cyc();
      end
      ivalid = 1'b0; oready = 1'b1;
      repeat (8) cyc();
      check("final_count", {29'd0, count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/chan_fifo.md
# chan_fifo

Parametrised valid/ready channel FIFO: the deep successor to the two-entry channel buffer. Carries WIDTH-bit words from an input channel to an output channel through DEPTH entries of storage, with registered handshake outputs, one word per cycle sustained throughput and an occupancy count. Used between producer/consumer blocks that need elastic buffering beyond a skid stage.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, total capacity in words, including the output register; power of two, ≥2
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- idata  input  WIDTH  input word
- ivalid  input  1  input word present
- iready  output  1  FIFO can accept; registered
- odata  output  WIDTH  output word; registered
- ovalid  output  1  odata holds a valid word; registered
- oready  input  1  consumer accepts odata
- count  output  $clog2(DEPTH+1)  words held (output register plus storage); registered

## Operation
- One clock; reset is asynchronous and active-low on resetn.
- Transfer rules:
  - A push occurs when ivalid && iready at a rising edge.
  - A pop occurs when ovalid && oready at a rising edge.
- Reset values: iready=1, ovalid=0, odata=0, count=0, read and write pointers=0.
- Storage: output register plus a circular array of DEPTH-1 entries.
  - Read and write pointers are $clog2(DEPTH-1)-bit or wider and wrap modulo DEPTH-1.
  - DEPTH=2 degenerates to a single storage entry.
- Output register load, priority order:
  1. If the output register is empty or popping and the array is non-empty: load the array head and advance the read pointer.
  2. Else, if the output register is empty or popping and a push occurs: load idata directly (bypass).
  3. Else: hold.
- Array write:
  - A pushed word not taken by bypass is written at the write pointer, and the pointer advances.
- Ordering: words leave in strict arrival order; no word is dropped or duplicated.
- count update: count_next = count + push − pop.
  - Never exceeds DEPTH and never underflows.
- Handshake outputs:
  - iready_next = (count_next < DEPTH).
  - ovalid_next = (count_next > 0).
- ivalid while iready=0 has no effect, and idata is ignored.
- oready while ovalid=0 has no effect.
- Simultaneous push and pop: count unchanged. Allowed in every state where iready=1 and ovalid=1.
- Full (count=DEPTH): iready=0.
  - A pop in this state makes iready=1 on the next cycle.
  - A push cannot happen in the same cycle as that pop (registered iready).
- Empty (count=0): ovalid=0; odata holds its last value.
- Reset mid-operation: all contents are discarded immediately and outputs return to reset values asynchronously.
- Storage array contents are not reset.

## Timing
- Latency: a word pushed into an empty FIFO appears on odata with ovalid=1 in the cycle after the push edge, i.e. 1 cycle.
- Latency, non-empty: a pushed word reaches odata one cycle after all earlier words have popped.
- Throughput:
  - With oready held at 1, one word per cycle in and out indefinitely.
  - Count stays at 1 in this steady state.
- After a full→not-full transition, iready rises one cycle after the pop. This causes one bubble only when the FIFO was full.
- All outputs change only on rising clock edges, or asynchronously on resetn falling.

## Structure
- No shared package needed. Pointer and count widths are derived locally from DEPTH with localparams.
- One sub-module: chan_fifo_mem.
  - Simple dual-port array, DEPTH-1 × WIDTH.
  - Synchronous write with enable.
  - Asynchronous (combinational) read at the read pointer.
  - No reset.
- chan_fifo holds the pointers, count, the output register and the handshake logic.

## Test plan
Each scenario uses WIDTH=8, DEPTH=4.

- Reset, then idle: iready=1, ovalid=0, count=0, odata=0. Assert resetn low mid-stream with count=3 → all outputs back to reset values before the next edge.
- Fill with oready=0: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - count goes 1,2,3,4 and iready=0 after the fourth push.
  - A fifth ivalid with 0x55 is not accepted.
  - odata=0x11 throughout.
- Drain: from full, oready=1 for 4 cycles → odata sequence 0x11, 0x22, 0x33, 0x44, then ovalid=0 and count=0. iready=1 one cycle after the first pop.
- Streaming: ivalid=oready=1 from empty, data 0x00..0x3F incrementing.
  - Output is 0x00..0x3F in order, one word per cycle.
  - First output one cycle after the first push; count stays at 1.
- Simultaneous push/pop at count=2 → count stays 2 and ordering is preserved.
- Random ivalid/oready at 50% over 10,000 cycles → scoreboard shows exact in-order delivery, count always matches the scoreboard occupancy, and count never exceeds 4.
